// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt formula pipeline: result word width and type.
package sqrt_pkg;

    localparam int SQRT_W = 32;

    typedef logic [SQRT_W-1:0] sqrt_res_t;

endpackage

// File: rtl/sqrt_result_fifo.sv
// Result FIFO for the sqrt collector: first-word fall-through storage with
// extended pointers, an occupancy counter and a sticky overflow flag.
module sqrt_result_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = SQRT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_req,
    output logic                     out_vld,
    output logic [W-1:0]             out_data,
    output logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          drop;

    // Extra pointer MSB separates the wrapped-full case from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = pop_req & ~empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign out_vld  = ~empty;
    assign out_data = mem[rd_ptr[AW-1:0]];

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Storage write; data words carry no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sqrt_result_collector.sv
// Collector behind the sqrt distributor: buffers the fixed-latency result
// stream and meters argument issue with credits so no result is ever lost.
module sqrt_result_collector
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = SQRT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    output logic                     issue_rdy,
    output logic                     dist_arg_vld,
    input  logic                     dist_res_vld,
    input  logic [W-1:0]             dist_res,
    output logic                     out_vld,
    output logic [W-1:0]             out_data,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   credits,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic pop;
    logic issue;

    // Issue gating: only combinational path is issue_vld -> dist_arg_vld.
    assign issue_rdy    = (credits != '0);
    assign issue        = issue_vld & issue_rdy;
    assign dist_arg_vld = issue;

    sqrt_result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dist_res_vld),
        .push_data (dist_res),
        .pop_req   (out_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .pop       (pop),
        .count     (count),
        .ovf_err   (ovf_err)
    );

    // Credit counter: issue takes one, pop returns one, never above DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CW'(DEPTH);
        end else begin
            if (issue && !pop) begin
                credits <= credits - 1'b1;
            end else if (pop && !issue && (credits != CW'(DEPTH))) begin
                credits <= credits + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_result_collector.sv
// Bench for sqrt_result_collector: plays the distributor with a variable-latency
// delay line and checks every cycle against a queue-based behavioural model.
module tb_sqrt_result_collector;
    import sqrt_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            issue_vld = 1'b0;
    logic            out_rdy = 1'b0;
    logic            force_vld = 1'b0;
    sqrt_res_t       force_dat = '0;
    logic            issue_rdy;
    logic            dist_arg_vld;
    logic            dist_res_vld;
    sqrt_res_t       dist_res;
    logic            out_vld;
    sqrt_res_t       out_data;
    logic [CW-1:0]   credits;
    logic [CW-1:0]   count;
    logic            ovf_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sqrt_result_collector #(.DEPTH(DEPTH), .W(SQRT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_vld    (issue_vld),
        .issue_rdy    (issue_rdy),
        .dist_arg_vld (dist_arg_vld),
        .dist_res_vld (dist_res_vld),
        .dist_res     (dist_res),
        .out_vld      (out_vld),
        .out_data     (out_data),
        .out_rdy      (out_rdy),
        .credits      (credits),
        .count        (count),
        .ovf_err      (ovf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Distributor stand-in: results return lat cycles after issue, values step by 4.
    logic      dl_vld [64];
    sqrt_res_t dl_dat [64];
    int        lat = 50;
    sqrt_res_t arg_val = 32'd3;
    int        n_issue = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++) dl_vld[k] <= 1'b0;
        end else begin
            for (int k = 63; k > 0; k--) begin
                dl_vld[k] <= dl_vld[k-1];
                dl_dat[k] <= dl_dat[k-1];
            end
            dl_vld[0] <= dist_arg_vld;
            dl_dat[0] <= arg_val;
            if (dist_arg_vld) begin
                arg_val <= arg_val + 32'd4;
                n_issue <= n_issue + 1;
            end
        end
    end

    assign dist_res_vld = force_vld | dl_vld[lat-1];
    assign dist_res     = force_vld ? force_dat : dl_dat[lat-1];

    // Behavioural model: a bounded queue plus a credit count.
    sqrt_res_t mq[$];
    int        mc = DEPTH;
    bit        movf = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mc = DEPTH;
            movf = 1'b0;
        end else begin
            bit m_issue, m_pop, m_push;
            m_issue = issue_vld && (mc != 0);
            m_pop   = (mq.size() != 0) && out_rdy;
            m_push  = dist_res_vld && ((mq.size() < DEPTH) || m_pop);
            if (dist_res_vld && !m_push) movf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(dist_res);
            if (m_issue && !m_pop) mc = mc - 1;
            else if (m_pop && !m_issue && mc < DEPTH) mc = mc + 1;
        end
    end

    // Per-cycle comparison and log of words handed to the consumer.
    sqrt_res_t obs[$];
    int        pcyc[$];
    int        cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("out_vld", 32'(out_vld), 32'(mq.size() != 0));
            chk("count", 32'(count), 32'(mq.size()));
            chk("credits", 32'(credits), 32'(mc));
            chk("issue_rdy", 32'(issue_rdy), 32'(mc != 0));
            chk("dist_arg_vld", 32'(dist_arg_vld), 32'(issue_vld && mc != 0));
            chk("ovf_err", 32'(ovf_err), 32'(movf));
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            if (out_vld && out_rdy) begin
                obs.push_back(out_data);
                pcyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (32'(count) != target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_count", 32'(count), 32'(target));
    endtask

    task automatic wait_obs(input int target, input int budget);
        int n = 0;
        while (obs.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_obs", 32'(obs.size()), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sqrt_res_t exp1 [5];
        sqrt_res_t exp3 [8];
        int        n0;

        // Reset state, dist_arg_vld follows issue_vld while in reset.
        issue_vld = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dist_arg_vld", 32'(dist_arg_vld), 32'd1);
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        issue_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Five issues, results 50 cycles later.
        exp1 = '{32'd3, 32'd7, 32'd11, 32'd15, 32'd19};
        lat = 50;
        out_rdy = 1'b1;
        obs.delete();
        issue_vld = 1'b1;
        repeat (5) tick();
        issue_vld = 1'b0;
        wait_obs(5, 80);
        for (int i = 0; i < 5 && i < obs.size(); i++) chk("t1_data", obs[i], exp1[i]);
        tick();
        chk("t1_credits", 32'(credits), 32'd8);

        // Stalled consumer: credits stop issue at DEPTH.
        out_rdy = 1'b0;
        n0 = n_issue;
        issue_vld = 1'b1;
        repeat (12) tick();
        chk("t2_issues", 32'(n_issue - n0), 32'd8);
        chk("t2_issue_rdy", 32'(issue_rdy), 32'd0);
        wait_count(8, 60);
        chk("t2_credits", 32'(credits), 32'd0);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("t2_rdy_after_pop", 32'(issue_rdy), 32'd1);
        tick();
        issue_vld = 1'b0;
        chk("t2_credits_reissue", 32'(credits), 32'd0);
        wait_count(8, 70);

        // Full FIFO: simultaneous pop and push.
        out_rdy = 1'b1;
        force_vld = 1'b1;
        force_dat = 32'hAAAA_0001;
        tick();
        out_rdy = 1'b0;
        force_vld = 1'b0;
        chk("t3_count", 32'(count), 32'd8);
        chk("t3_ovf", 32'(ovf_err), 32'd0);
        chk("t3_credits", 32'(credits), 32'd1);

        // Full FIFO, no pop: word dropped, overflow sticky.
        force_vld = 1'b1;
        force_dat = 32'hBBBB_0002;
        tick();
        force_vld = 1'b0;
        chk("t4_ovf", 32'(ovf_err), 32'd1);
        chk("t4_count", 32'(count), 32'd8);
        repeat (3) tick();
        chk("t4_ovf_sticky", 32'(ovf_err), 32'd1);

        // Drain, order preserved across the wrap.
        exp3 = '{32'd31, 32'd35, 32'd39, 32'd43, 32'd47, 32'd51, 32'd55, 32'hAAAA_0001};
        obs.delete();
        out_rdy = 1'b1;
        wait_count(0, 20);
        chk("t4_drain_n", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++) chk("t4_drain_data", obs[i], exp3[i]);
        chk("t4_credits", 32'(credits), 32'd8);

        // Back-to-back traffic, short latency.
        lat = 4;
        obs.delete();
        pcyc.delete();
        issue_vld = 1'b1;
        repeat (50) tick();
        chk("t5_credits_mid", 32'(credits), 32'd3);
        repeat (50) tick();
        chk("t5_credits_end", 32'(credits), 32'd3);
        issue_vld = 1'b0;
        wait_obs(100, 30);
        for (int i = 0; i < 100 && i < obs.size(); i++)
            chk("t5_data", obs[i], 32'd59 + 32'(4 * i));
        if (pcyc.size() >= 100) chk("t5_no_bubble", 32'(pcyc[99] - pcyc[0]), 32'd99);
        else chk("t5_pops", 32'(pcyc.size()), 32'd100);

        // Reset with four words buffered.
        out_rdy = 1'b0;
        issue_vld = 1'b1;
        repeat (4) tick();
        issue_vld = 1'b0;
        wait_count(4, 20);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_out_vld", 32'(out_vld), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_credits", 32'(credits), 32'd8);
        chk("t6_ovf", 32'(ovf_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) tick();
        chk("t6_no_stale", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
